muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_div_core.sv | 29 ++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFFFFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's complement magnitude of a value when it is treated as signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        abs_val = (is_signed && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// One restoring-division step: shift the dividend MSB into the remainder,
// trial-subtract the divisor and shift the resulting quotient bit in.
module div_core
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Trial subtraction; a borrow in the top bit restores the shifted remainder.
    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (diff[XLEN]) begin
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide sharing one 64-bit accumulator (hi = remainder, lo = quotient).
// Optional build macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          f3_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic                busy_q;
    logic                done_q;
    logic                we_q;
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_q;

    logic                sgn_a_c, sgn_b_c, sa_c, sb_c, neg_c;
    logic                div0_c, ovf_c;
    logic [XLEN-1:0]     mag_a_c, mag_b_c;
    logic [XLEN:0]       mul_sum_c;
    logic [2*XLEN-1:0]   mul_step_c;
    logic [XLEN-1:0]     div_rem_c, div_quot_c;
    logic [2*XLEN-1:0]   prod_c;
    logic [XLEN-1:0]     quo_c, rem_c, sel_c;

    // Operand signedness, magnitudes, result sign and special-case detection at accept.
    always_comb begin
        sgn_a_c = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                  (funct3 == F3_DIV)  || (funct3 == F3_REM);
        sgn_b_c = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa_c    = sgn_a_c && op_a[XLEN-1];
        sb_c    = sgn_b_c && op_b[XLEN-1];
        mag_a_c = abs_val(op_a, sgn_a_c);
        mag_b_c = abs_val(op_b, sgn_b_c);
        neg_c   = (funct3 == F3_REM) ? sa_c : (sa_c ^ sb_c);
        div0_c  = funct3[2] && (op_b == '0);
        ovf_c   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == INT_MIN) && (op_b == DIV0_QUOT);
    end

    // Shift-add multiply step: conditionally add multiplicand to the high half, shift right.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end

    div_core u_div_core (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quot_i    (acc_q[XLEN-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem_c),
        .quot_o    (div_quot_c)
    );

    // Sign correction and output selection for the DONE state.
    always_comb begin
        prod_c = neg_q ? (2*XLEN)'(-acc_q) : acc_q;
        quo_c  = neg_q ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_c  = neg_q ? XLEN'(-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       sel_c = prod_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel_c = prod_c[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              sel_c = quo_c;
            default:                      sel_c = rem_c;
        endcase
    end

    // Control FSM with registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_q   <= funct3;
                        rd_q   <= rd_in;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (div0_c) begin
                            acc_q   <= {op_a, DIV0_QUOT};
                            neg_q   <= 1'b0;
                            state_q <= DONE;
                        end else if (ovf_c) begin
                            acc_q   <= {{XLEN{1'b0}}, INT_MIN};
                            neg_q   <= 1'b0;
                            state_q <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            acc_q   <= (2*XLEN)'(mag_a_c) * (2*XLEN)'(mag_b_c);
                            neg_q   <= neg_c;
                            state_q <= DONE;
`endif
                        end else begin
                            neg_q   <= neg_c;
                            acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_c : mag_b_c)};
                            opnd_q  <= funct3[2] ? mag_b_c : mag_a_c;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= f3_q[2] ? {div_rem_c, div_quot_c} : mul_step_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q <= sel_c;
                    done_q   <= 1'b1;
                    we_q     <= (rd_q != 5'd0);
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we_out = we_q;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected values.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      rd_in;
    logic            busy, done, we_out;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one op, optionally poke start mid-operation, then check latency and outputs.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat, input bit poke);
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy_acc"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            if (poke && lat == 5) begin
                start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check_eq({tag, "_we"}, 32'(we_out), 32'(rd != 5'd0));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_we", 32'(we_out), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul", F3_MUL, 32'd7, 32'd6, 5'd3, 32'h0000002A, MUL_LAT, 1'b0);
        run_op("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, MUL_LAT, 1'b0);
        run_op("mulh", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000, MUL_LAT, 1'b0);
        run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd6, 32'hFFFFFFFF, MUL_LAT, 1'b0);
        run_op("div", F3_DIV, 32'hFFFFFFEC, 32'd3, 5'd7, 32'hFFFFFFFA, DIV_LAT, 1'b0);
        run_op("rem", F3_REM, 32'hFFFFFFEC, 32'd3, 5'd8, 32'hFFFFFFFE, DIV_LAT, 1'b0);
        run_op("divu", F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, DIV_LAT, 1'b0);
        run_op("remu", F3_REMU, 32'd100, 32'd7, 5'd10, 32'd2, DIV_LAT, 1'b0);
        run_op("divu0", F3_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, SPC_LAT, 1'b0);
        run_op("rem0", F3_REM, 32'd5, 32'd0, 5'd12, 32'd5, SPC_LAT, 1'b0);
        run_op("divovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, SPC_LAT, 1'b0);
        run_op("removf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, SPC_LAT, 1'b0);
        run_op("mul_poke", F3_MUL, 32'd7, 32'd6, 5'd3, 32'h0000002A, MUL_LAT, 1'b1);
        run_op("mul_rd0", F3_MUL, 32'd2, 32'd3, 5'd0, 32'd6, MUL_LAT, 1'b0);

        // Abort a divide with reset 10 cycles after accept.
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd15;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_eq("abort_no_pulse", 32'(pulses), 32'd0);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);

        run_op("post_abort", F3_DIVU, 32'd100, 32'd7, 5'd2, 32'd14, DIV_LAT, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
